// File: rtl/square_pkg.sv
// Shared constants, types and the slot seeding function for the square
// bank and the square-motion block.
package square_pkg;

    localparam int X_MAX       = 639;
    localparam int Y_MAX       = 479;
    localparam int SQUARE_SIZE = 10;

    localparam int SLOT_W  = 40;
    localparam int COORD_W = 10;

    localparam int SQ_X_OFF = 0;
    localparam int SQ_Y_OFF = 10;
    localparam int XD_OFF   = 20;
    localparam int YD_OFF   = 30;

    localparam logic [COORD_W-1:0] VEL_POS = 10'h002;
    localparam logic [COORD_W-1:0] VEL_NEG = 10'h3FE;

    typedef enum logic [1:0] {
        IDLE,
        SEED,
        RUN
    } state_t;

    // Out-of-range coordinates fold back by a power of two so the square
    // stays on screen; zero is nudged to 1 to keep it off the border.
    function automatic logic [SLOT_W-1:0] seed_slot(
        input logic [19:0] r,
        input int          x_lim,
        input int          y_lim
    );
        logic [COORD_W-1:0] rx;
        logic [COORD_W-1:0] ry;
        logic [SLOT_W-1:0]  s;
        rx = r[9:0];
        if (int'(rx) > x_lim) rx = rx - 10'd512;
        if (rx == 10'd0) rx = 10'd1;
        ry = {1'b0, r[18:10]};
        if (int'(ry) > y_lim) ry = ry - 10'd256;
        if (ry == 10'd0) ry = 10'd1;
        s = '0;
        s[SQ_X_OFF +: COORD_W] = rx;
        s[SQ_Y_OFF +: COORD_W] = ry;
        s[XD_OFF +: COORD_W]   = r[19] ? VEL_NEG : VEL_POS;
        s[YD_OFF +: COORD_W]   = r[0] ? VEL_NEG : VEL_POS;
        return s;
    endfunction

endpackage

// File: rtl/lfsr20.sv
// 20-bit Fibonacci LFSR, taps 20 and 17, advancing only when enabled.
module lfsr20 #(
    parameter logic [19:0] SEED = 20'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [19:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[18:0], q[19] ^ q[16]};
        end
    end

endmodule

// File: rtl/square_bank.sv
// Bank of square slots: seeds positions from an LFSR, then commits the
// motion block's updates one cycle after each frame tick.
module square_bank #(
    parameter int          NUM_SQ      = 16,
    parameter int          X_MAX       = square_pkg::X_MAX,
    parameter int          Y_MAX       = square_pkg::Y_MAX,
    parameter int          SQUARE_SIZE = square_pkg::SQUARE_SIZE,
    parameter logic [19:0] LFSR_SEED   = 20'hACE1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4:0]             num_square,
    input  logic                   refresh_tick,
    input  logic [NUM_SQ*40-1:0]   position_next,
    output logic [NUM_SQ*40-1:0]   position,
    output logic [NUM_SQ-1:0]      active_mask,
    output logic                   busy
);

    import square_pkg::*;

    localparam int SW = SLOT_W;
    localparam int CW = (NUM_SQ > 1) ? $clog2(NUM_SQ) : 1;
    localparam int X_LIM = X_MAX - SQUARE_SIZE - 1;
    localparam int Y_LIM = Y_MAX - SQUARE_SIZE - 1;

    state_t            state_q;
    state_t            state_d;
    logic [CW-1:0]     cnt_q;
    logic              tick_q;
    logic              accept;
    logic              seed_wr;
    logic              last;
    logic              commit;
    logic [19:0]       lfsr_q;
    logic [NUM_SQ-1:0] mask_new;
    logic [SW-1:0]     slot_wr;
    logic [NUM_SQ*SW-1:0] commit_vec;
    int                n;

    lfsr20 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (reset),
        .en    (seed_wr),
        .q     (lfsr_q)
    );

    assign last   = (cnt_q == CW'(NUM_SQ - 1));
    assign busy   = (state_q == SEED);
    assign commit = tick_q && (state_q == RUN);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        seed_wr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = SEED;
                end
            end
            SEED: begin
                seed_wr = 1'b1;
                if (last) state_d = RUN;
            end
            RUN: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = SEED;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Requested count clamps into 1..NUM_SQ.
    always_comb begin
        n = int'(num_square);
        if (n == 0) n = 1;
        if (n > NUM_SQ) n = NUM_SQ;
        mask_new = '0;
        for (int i = 0; i < NUM_SQ; i++) begin
            mask_new[i] = (i < n);
        end
    end

    always_comb begin
        slot_wr = '0;
        if (active_mask[cnt_q]) slot_wr = seed_slot(lfsr_q, X_LIM, Y_LIM);
    end

    always_comb begin
        commit_vec = '0;
        for (int i = 0; i < NUM_SQ; i++) begin
            if (active_mask[i]) commit_vec[i*SW +: SW] = position_next[i*SW +: SW];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tick_q      <= 1'b0;
            active_mask <= '0;
            position    <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= refresh_tick && (state_q == RUN);
            if (accept) begin
                cnt_q       <= '0;
                active_mask <= mask_new;
            end else if (seed_wr) begin
                cnt_q <= last ? '0 : cnt_q + 1'b1;
            end
            if (seed_wr) begin
                position[int'(cnt_q)*SW +: SW] <= slot_wr;
            end else if (commit) begin
                position <= commit_vec;
            end
        end
    end

endmodule

// File: tb/tb_square_bank.sv
// Directed bench for square_bank with an independent LFSR/slot model.
module tb_square_bank;

    logic         clk;
    logic         reset;
    logic         start;
    logic [4:0]   num_square;
    logic         refresh_tick;
    logic [639:0] position_next;
    logic [639:0] position;
    logic [15:0]  active_mask;
    logic         busy;

    int vectors;
    int miscompares;
    int c;

    logic [19:0]  mlfsr;
    logic [639:0] exp_pos;
    logic [639:0] exp34;
    logic [639:0] held;

    square_bank #(
        .LFSR_SEED(20'h003E8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .num_square    (num_square),
        .refresh_tick  (refresh_tick),
        .position_next (position_next),
        .position      (position),
        .active_mask   (active_mask),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] lstep(input logic [19:0] r);
        return {r[18:0], r[19] ^ r[16]};
    endfunction

    function automatic logic [39:0] mslot(input logic [19:0] r);
        logic [9:0] x;
        logic [9:0] y;
        x = r[9:0];
        if (x > 10'd628) x = x - 10'd512;
        if (x == 10'd0) x = 10'd1;
        y = {1'b0, r[18:10]};
        if (y > 10'd468) y = y - 10'd256;
        if (y == 10'd0) y = 10'd1;
        return {(r[0] ? 10'h3FE : 10'h002), (r[19] ? 10'h3FE : 10'h002), y, x};
    endfunction

    task automatic check(input string tag, input logic [639:0] obs,
                         input logic [639:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_seed(input int n);
        for (int k = 0; k < 16; k++) begin
            exp_pos[k*40 +: 40] = (k < n) ? mslot(mlfsr) : 40'd0;
            mlfsr = lstep(mlfsr);
        end
    endtask

    task automatic do_start(input logic [4:0] num);
        @(negedge clk);
        start      = 1'b1;
        num_square = num;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic count_busy(input string tag);
        c = 0;
        while (busy && c < 40) begin
            c++;
            @(negedge clk);
        end
        check(tag, 640'(c), 640'd16);
    endtask

    task automatic range_check(input string tag);
        logic       ok;
        logic [9:0] x;
        logic [9:0] y;
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (active_mask[i]) begin
                x = position[i*40 +: 10];
                y = position[i*40+10 +: 10];
                if (x < 10'd1 || x > 10'd628 || y < 10'd1 || y > 10'd468) ok = 1'b0;
            end
        end
        check(tag, 640'(ok), 640'd1);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b0;
        start         = 1'b0;
        num_square    = 5'd0;
        refresh_tick  = 1'b0;
        position_next = {16{40'hA5A5A5A5A5}};
        mlfsr         = 20'h003E8;

        repeat (2) @(negedge clk);
        check("rst_position", position, 640'd0);
        check("rst_mask", 640'(active_mask), 640'd0);
        check("rst_busy", 640'(busy), 640'd0);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            refresh_tick = ~refresh_tick;
            @(negedge clk);
        end
        refresh_tick = 1'b0;
        check("idle_position", position, 640'd0);
        check("idle_busy", 640'(busy), 640'd0);

        do_start(5'd3);
        check("mask_n3", 640'(active_mask), 640'h0007);
        count_busy("busy_n3");
        model_seed(3);
        exp34 = exp_pos;
        check("slot0_n3", 640'(position[39:0]),
              640'({10'h002, 10'h002, 10'd1, 10'd488}));
        check("seed_n3", position, exp_pos);

        @(negedge clk);
        check("run_no_tick", position, exp_pos);
        refresh_tick = 1'b1;
        @(negedge clk);
        refresh_tick = 1'b0;
        check("tick_not_yet", position, exp_pos);
        @(negedge clk);
        exp_pos = '0;
        for (int i = 0; i < 3; i++) exp_pos[i*40 +: 40] = 40'hA5A5A5A5A5;
        check("tick_commit", position, exp_pos);
        position_next = {16{40'h123456789A}};
        repeat (2) @(negedge clk);
        check("run_hold", position, exp_pos);

        do_start(5'd0);
        check("mask_n0", 640'(active_mask), 640'h0001);
        count_busy("busy_n0");
        model_seed(1);
        check("seed_n0", position, exp_pos);
        range_check("range_n0");

        do_start(5'd20);
        check("mask_n20", 640'(active_mask), 640'hFFFF);
        count_busy("busy_n20");
        model_seed(16);
        check("seed_n20", position, exp_pos);
        range_check("range_n20");

        do_start(5'd3);
        repeat (7) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_position", position, 640'd0);
        check("async_mask", 640'(active_mask), 640'd0);
        check("async_busy", 640'(busy), 640'd0);
        @(negedge clk);
        reset = 1'b1;
        mlfsr = 20'h003E8;
        do_start(5'd3);
        count_busy("busy_rerun");
        model_seed(3);
        check("rerun_matches", position, exp34);

        do_start(5'd5);
        c = 0;
        while (busy && c < 40) begin
            c++;
            start        = (c == 4);
            num_square   = 5'd20;
            refresh_tick = (c >= 4);
            @(negedge clk);
        end
        start        = 1'b0;
        refresh_tick = 1'b0;
        check("busy_ignore_start", 640'(c), 640'd16);
        check("mask_ignore_start", 640'(active_mask), 640'h001F);
        model_seed(5);
        check("seed_no_commit", position, exp_pos);
        held = exp_pos;
        repeat (2) @(negedge clk);
        check("last_edge_no_commit", position, held);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
